// File: rtl/poly_dec_pkg.sv
// Shared defaults, width helpers and FSM state type for the polyphase decimator controller.
package poly_dec_pkg;

  localparam int unsigned N_PHASE_DEF = 8;
  localparam int unsigned W_IN_DEF    = 8;
  localparam int unsigned W_BR_DEF    = 20;
  localparam int unsigned BR_LAT_DEF  = 1;

  // Phase/index counter width.
  function automatic int unsigned phase_w(input int unsigned n_phase);
    return $clog2(n_phase);
  endfunction

  // Sum of n_phase branch words needs log2(n_phase) guard bits.
  function automatic int unsigned w_out(input int unsigned n_phase, input int unsigned w_br);
    return w_br + $clog2(n_phase);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSum,
    StHold
  } state_e;

endpackage

// File: rtl/poly_branch_accum.sv
// Snapshot of all branch outputs, serial sign-extended summation and output handshake.
module poly_branch_accum
  import poly_dec_pkg::*;
#(
  parameter int unsigned N_PHASE = N_PHASE_DEF,
  parameter int unsigned W_BR    = W_BR_DEF,
  parameter int unsigned W_OUT   = w_out(N_PHASE_DEF, W_BR_DEF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    snap,
  input  logic [N_PHASE*W_BR-1:0] br_y,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    out_valid,
  output logic [W_OUT-1:0]        out_data
);

  localparam int unsigned IDX_W = phase_w(N_PHASE);
  localparam int unsigned EXT_W = W_OUT - W_BR;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PHASE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W_OUT-1:0] acc_q, acc_d;
  logic [W_OUT-1:0] sum;
  logic [W_OUT-1:0] out_data_d;
  logic             out_valid_d;
  logic [W_BR-1:0]  cap_q [N_PHASE];
  logic [W_BR-1:0]  cap_sel;

  assign cap_sel = cap_q[idx_q];
  assign sum     = acc_q + {{EXT_W{cap_sel[W_BR-1]}}, cap_sel};
  assign busy    = (state_q != StIdle);

  // Next-state, accumulator and output register updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    unique case (state_q)
      StIdle: begin
        if (arm) state_d = StSettle;
      end
      StSettle: begin
        if (snap) begin
          state_d = StSum;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StSum: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d     = StHold;
          out_data_d  = sum;
          out_valid_d = 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, accumulator and output state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

  // Capture bank, loaded once per frame at the snap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < N_PHASE; p++) cap_q[p] <= '0;
    end else if (state_q == StSettle && snap) begin
      for (int p = 0; p < N_PHASE; p++) cap_q[p] <= br_y[p*W_BR +: W_BR];
    end
  end

endmodule

// File: rtl/poly_dec_ctrl.sv
// Polyphase decimator sequencer: sample commutator, snap timing and summation engine.
module poly_dec_ctrl
  import poly_dec_pkg::*;
#(
  parameter int unsigned N_PHASE = N_PHASE_DEF,
  parameter int unsigned W_IN    = W_IN_DEF,
  parameter int unsigned W_BR    = W_BR_DEF,
  parameter int unsigned BR_LAT  = BR_LAT_DEF,
  parameter int unsigned W_OUT   = w_out(N_PHASE, W_BR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_IN-1:0]         in_data,
  output logic [N_PHASE-1:0]      br_ce,
  output logic [W_IN-1:0]         br_x,
  input  logic [N_PHASE*W_BR-1:0] br_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W_OUT-1:0]        out_data
);

  localparam int unsigned PH_W = phase_w(N_PHASE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASE - 1);

  logic [PH_W-1:0]    phase_q, phase_d;
  logic [N_PHASE-1:0] br_ce_d;
  logic [BR_LAT:0]    snap_q;
  logic               last_phase, accept, frame_end, engine_busy, snap;

  assign last_phase = (phase_q == PH_LAST);
  // Only the frame-ending sample waits for the engine; the snapshot is taken before any
  // next-frame branch update becomes visible.
  assign in_ready   = ~reset & ~sync & ~(last_phase & engine_busy);
  assign accept     = in_valid & in_ready;
  assign frame_end  = accept & last_phase;
  assign snap       = snap_q[BR_LAT];

  // Phase advance and one-hot branch enable for the accepted sample.
  always_comb begin
    phase_d = phase_q;
    br_ce_d = '0;
    if (sync) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d          = last_phase ? '0 : phase_q + 1'b1;
      br_ce_d[phase_q] = 1'b1;
    end
  end

  // Commutator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      br_ce   <= '0;
      br_x    <= '0;
    end else begin
      phase_q <= phase_d;
      br_ce   <= br_ce_d;
      if (accept) br_x <= in_data;
    end
  end

  // Snap fires 1+BR_LAT cycles after the frame-end accept, when the last branch is settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else begin
      snap_q <= {snap_q[BR_LAT-1:0], frame_end};
    end
  end

  poly_branch_accum #(
    .N_PHASE (N_PHASE),
    .W_BR    (W_BR),
    .W_OUT   (W_OUT)
  ) u_accum (
    .clk       (clk),
    .reset     (reset),
    .arm       (frame_end),
    .snap      (snap),
    .br_y      (br_y),
    .out_ready (out_ready),
    .busy      (engine_busy),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_poly_dec_ctrl.sv
// Self-checking bench for poly_dec_ctrl with stub branch filters and an output scoreboard.
module tb_poly_dec_ctrl;

  localparam int unsigned N      = 8;
  localparam int unsigned W_IN   = 8;
  localparam int unsigned W_BR   = 20;
  localparam int unsigned BR_LAT = 1;
  localparam int unsigned W_OUT  = 23;
  localparam int          LAT    = 2 + BR_LAT + N;
  localparam logic [W_BR-1:0]  BR_MAX  = 20'h7FFFF;
  localparam logic [W_OUT-1:0] SUM_MAX = 23'd4194296;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sync = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W_IN-1:0]   in_data = '0;
  logic [N-1:0]      br_ce;
  logic [W_IN-1:0]   br_x;
  logic [N*W_BR-1:0] br_y;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [W_OUT-1:0]  out_data;
  logic              force_max = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  poly_dec_ctrl #(
    .N_PHASE (N),
    .W_IN    (W_IN),
    .W_BR    (W_BR),
    .BR_LAT  (BR_LAT),
    .W_OUT   (W_OUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .br_ce     (br_ce),
    .br_x      (br_x),
    .br_y      (br_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub branches: one register stage gives BR_LAT = 1.
  logic [W_BR-1:0] stub_y [N];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < N; p++) stub_y[p] <= '0;
    end else begin
      for (int p = 0; p < N; p++)
        if (br_ce[p]) stub_y[p] <= {{(W_BR-W_IN){br_x[W_IN-1]}}, br_x};
    end
  end

  always_comb begin
    br_y = '0;
    for (int p = 0; p < N; p++) br_y[p*W_BR +: W_BR] = force_max ? BR_MAX : stub_y[p];
  end

  // Scoreboard: expected sum and expected first-valid cycle per frame.
  typedef struct {
    logic [W_OUT-1:0] data;
    int               cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_pop;
  int               m_phase = 0;
  logic [W_OUT-1:0] m_sum = '0;
  logic [N-1:0]     exp_ce = '0;
  logic [W_IN-1:0]  exp_x = '0;
  logic             ov_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_sum   = '0;
      exp_ce  = '0;
      exp_x   = '0;
      ov_prev = 1'b0;
      exp_q.delete();
    end else begin
      checks++;
      if (br_ce !== exp_ce) begin
        failures++;
        $display("FAIL br_ce: got %h want %h (cycle %0d)", br_ce, exp_ce, cyc);
      end
      checks++;
      if (br_x !== exp_x) begin
        failures++;
        $display("FAIL br_x: got %h want %h (cycle %0d)", br_x, exp_x, cyc);
      end
      if (out_valid && !ov_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL latency: out_valid with no frame expected (cycle %0d)", cyc);
        end else if (cyc != exp_q[0].cyc) begin
          failures++;
          $display("FAIL latency: out_valid at cycle %0d want %0d", cyc, exp_q[0].cyc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_data: unexpected output %h", out_data);
        end else begin
          e_pop = exp_q.pop_front();
          if (out_data !== e_pop.data) begin
            failures++;
            $display("FAIL out_data: got %h want %h", out_data, e_pop.data);
          end
        end
      end
      ov_prev = out_valid;
      exp_ce  = '0;
      if (sync) begin
        m_phase = 0;
        m_sum   = '0;
      end else if (in_valid && in_ready) begin
        exp_ce[m_phase] = 1'b1;
        exp_x = in_data;
        m_sum = m_sum + {{(W_OUT-W_IN){in_data[W_IN-1]}}, in_data};
        if (m_phase == N - 1) begin
          exp_q.push_back('{data: force_max ? SUM_MAX : m_sum, cyc: cyc + LAT});
          m_phase = 0;
          m_sum   = '0;
        end else begin
          m_phase++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W_IN-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles want 1", n);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d outputs pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++;
    if (br_ce !== '0) begin failures++; $display("FAIL rst_br_ce: got %h want 0", br_ce); end
    checks++;
    if (br_x !== '0) begin failures++; $display("FAIL rst_br_x: got %h want 0", br_x); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(W_IN'(i));
    drain();
  endtask

  task automatic test_negative();
    for (int i = 0; i < 8; i++) send(8'h80);
    drain();
  endtask

  task automatic test_max_sum();
    force_max = 1'b1;
    for (int i = 0; i < 8; i++) send(W_IN'(i));
    drain();
    force_max = 1'b0;
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    for (int i = 1; i <= 15; i++) send(W_IN'(i));
    in_valid = 1'b1;
    in_data  = 8'd16;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stall: in_ready got %b want 0 (cycle %0d)", in_ready, cyc);
      end
      if (c >= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 23'd36) begin
          failures++;
          $display("FAIL hold_stable: got valid=%b data=%0d want valid=1 data=36",
                   out_valid, out_data);
        end
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(8'd16);
    for (int c = 0; c < 14; c++) step();
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_sync();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(8'd5);
    sync     = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd7;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL sync_ready: got %b want 0", in_ready); end
    step();
    sync     = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd2);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) send(8'd3);
    for (int c = 0; c < 4; c++) step();
    reset = 1'b1;
    #1;
    checks++;
    if (br_ce !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got ce=%h valid=%b ready=%b want 0/0/0",
               br_ce, out_valid, in_ready);
    end
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL dropped_out: got %b want 0", out_valid); end
      step();
    end
    for (int i = 0; i < 8; i++) send(8'd1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_negative();
    test_max_sum();
    test_hold();
    test_sync();
    test_reset_mid();
    for (int c = 0; c < 4; c++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
